// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes, FSM encodings and small helpers shared by the LCD driver
package lcd_pkg;
  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {PWR_WAIT, INIT_CMD, SET_ADDR, FETCH, WR_CHAR, IDLE} lcd_state_t;
  typedef enum logic [1:0] {B_IDLE, B_SETUP, B_PULSE, B_WAIT} bus_state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    return step == 2'd0 ? LCD_FUNC_SET :
           step == 2'd1 ? LCD_DISP_ON  :
           step == 2'd2 ? LCD_ENTRY    : LCD_CLEAR;
  endfunction

  // DDRAM address for a screen position: bit 4 selects the line
  function automatic logic [7:0] line_addr(input logic [4:0] idx);
    return (idx[4] ? LCD_LINE2 : LCD_LINE1) + {4'd0, idx[3:0]};
  endfunction
endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: one HD44780 bus write (setup, E pulse, post-write wait) per accepted req
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 5,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  input  logic       long_wait,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);
  bus_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_rs, r_long;
  logic [7:0]       r_data;
  logic             w_zero, w_accept;

  assign w_zero   = r_cnt == '0;
  assign w_accept = r_state == B_IDLE && req;
  assign lcd_e    = r_state == B_PULSE;
  assign lcd_rs   = r_rs;
  assign lcd_data = r_data;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_zero ? r_cnt : r_cnt - 1'b1;
    done        = 1'b0;
    case (r_state)
      B_IDLE: if (req) begin
        w_state_nxt = B_SETUP;
        w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
      end
      B_SETUP: if (w_zero) begin
        w_state_nxt = B_PULSE;
        w_cnt_nxt   = CNT_W'(E_PULSE_CYC - 1);
      end
      B_PULSE: if (w_zero) begin
        w_state_nxt = B_WAIT;
        w_cnt_nxt   = r_long ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
      end
      B_WAIT: if (w_zero) begin
        w_state_nxt = B_IDLE;
        done        = 1'b1;
      end
      default: w_state_nxt = B_IDLE;
    endcase
  end

  // RS/DATA are captured only on accept, so they cannot move during the E pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= B_IDLE;
      r_cnt   <= '0;
      r_rs    <= 1'b0;
      r_data  <= '0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rs   <= rs_in;
        r_data <= data_in;
        r_long <= long_wait;
      end
    end
  end
endmodule

// File: rtl/lcd_char_driver.sv
// lcd_char_driver: powers up and initialises a 16x2 character LCD, then refreshes it from the set-screen generator
module lcd_char_driver
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC      = 750000,
  parameter int SETUP_CYC      = 5,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);
  lcd_state_t       r_state, w_state_nxt;
  logic [1:0]       r_step, w_step_nxt;
  logic [CNT_W-1:0] r_tmr, w_tmr_nxt;
  logic [4:0]       r_index, w_index_nxt, w_index_inc;
  logic [7:0]       r_buf, w_buf_nxt, w_data;
  logic             r_busy, w_busy_nxt;
  logic             r_init_done, w_init_nxt;
  logic             r_frame_done, w_frame_nxt;
  logic             w_req, w_rs, w_long, w_done;

  assign index       = r_index;
  assign init_done   = r_init_done;
  assign frame_done  = r_frame_done;
  assign lcd_rw      = 1'b0;
  assign w_index_inc = r_index + 5'd1;

  // one request per write state; r_busy blocks re-requesting until done
  assign w_req  = (r_state == INIT_CMD || r_state == SET_ADDR || r_state == WR_CHAR) && !r_busy;
  assign w_rs   = r_state == WR_CHAR;
  assign w_long = r_state == INIT_CMD && r_step == 2'd3;
  assign w_data = r_state == INIT_CMD ? init_cmd(r_step) :
                  r_state == SET_ADDR ? line_addr(r_index) : r_buf;

  lcd_bus_writer #(
    .SETUP_CYC      (SETUP_CYC),
    .E_PULSE_CYC    (E_PULSE_CYC),
    .CMD_WAIT_CYC   (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
    .CNT_W          (CNT_W)
  ) u_bus (
    .clk       (clk),
    .rst       (rst),
    .req       (w_req),
    .rs_in     (w_rs),
    .data_in   (w_data),
    .long_wait (w_long),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data),
    .done      (w_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_tmr_nxt   = r_tmr;
    w_index_nxt = r_index;
    w_buf_nxt   = r_buf;
    w_init_nxt  = r_init_done;
    w_frame_nxt = 1'b0;
    w_busy_nxt  = w_req ? 1'b1 : w_done ? 1'b0 : r_busy;
    case (r_state)
      PWR_WAIT: if (r_tmr == CNT_W'(PWRUP_CYC - 1)) begin
        w_state_nxt = INIT_CMD;
        w_step_nxt  = 2'd0;
        w_tmr_nxt   = '0;
      end else w_tmr_nxt = r_tmr + 1'b1;
      INIT_CMD: if (w_done) begin
        if (r_step == 2'd3) begin
          w_init_nxt  = 1'b1;
          w_index_nxt = '0;
          w_state_nxt = en ? SET_ADDR : IDLE;
        end else w_step_nxt = r_step + 2'd1;
      end
      SET_ADDR: if (w_done) begin
        w_state_nxt = en ? FETCH : IDLE;
        w_tmr_nxt   = '0;
      end
      // two settle clocks cover the generator's registered output, third clock latches
      FETCH: if (r_tmr == CNT_W'(2)) begin
        w_buf_nxt   = char_in;
        w_state_nxt = WR_CHAR;
      end else w_tmr_nxt = r_tmr + 1'b1;
      WR_CHAR: if (w_done) begin
        w_index_nxt = w_index_inc;
        w_frame_nxt = r_index == 5'd31;
        w_tmr_nxt   = '0;
        w_state_nxt = !en ? IDLE : w_index_inc[3:0] == 4'd0 ? SET_ADDR : FETCH;
      end
      IDLE: if (en) w_state_nxt = SET_ADDR;
      default: w_state_nxt = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= PWR_WAIT;
      r_step       <= 2'd0;
      r_tmr        <= '0;
      r_index      <= '0;
      r_buf        <= '0;
      r_busy       <= 1'b0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_step       <= w_step_nxt;
      r_tmr        <= w_tmr_nxt;
      r_index      <= w_index_nxt;
      r_buf        <= w_buf_nxt;
      r_busy       <= w_busy_nxt;
      r_init_done  <= w_init_nxt;
      r_frame_done <= w_frame_nxt;
    end
  end
endmodule

// File: tb/tb_lcd_char_driver.sv
// tb_lcd_char_driver: bus-level monitor plus screen-content model for the LCD character driver
module tb_lcd_char_driver;
  localparam int PW = 10, SU = 2, EP = 3, CW = 4, CLW = 8;

  logic       clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [7:0] char_in, lcd_data;
  logic [4:0] index;
  logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;

  always #5 clk = ~clk;

  lcd_char_driver #(
    .PWRUP_CYC(PW), .SETUP_CYC(SU), .E_PULSE_CYC(EP),
    .CMD_WAIT_CYC(CW), .CLEAR_WAIT_CYC(CLW), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .char_in(char_in), .index(index),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .init_done(init_done), .frame_done(frame_done)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // character generator: registered lookup, optional extra clock of latency, optional corruption while E is high
  logic [7:0] scr [32];
  logic [7:0] g1, g2;
  logic       lat2 = 1'b0, corrupt = 1'b0;
  always @(posedge clk) begin
    g1 <= scr[index];
    g2 <= g1;
  end
  assign char_in = (corrupt && lcd_e) ? ~(lat2 ? g2 : g1) : (lat2 ? g2 : g1);

  typedef struct {logic rs; logic [7:0] data; logic idone;} wr_t;
  wr_t cap [$];

  int         rel, stable, hi, lo, fd_cnt;
  logic       prev_e, first, last_clr;
  logic [8:0] prev_bus;
  always @(negedge clk) begin
    if (!rst) begin
      rel = 0; stable = 0; hi = 0; lo = 0; fd_cnt = 0;
      prev_e = 1'b0; first = 1'b1; last_clr = 1'b0; prev_bus = '0;
    end else begin
      rel++;
      if ({lcd_rs, lcd_data} != prev_bus) stable = 0; else stable++;
      if (frame_done) fd_cnt++;
      if (lcd_e && !prev_e) begin
        chk("setup_before_e", 32'(stable >= SU), 1);
        if (first) chk("pwrup_wait", 32'(rel >= PW + SU), 1);
        else chk("gap_before_e", 32'(lo >= (last_clr ? CLW : CW) + SU + 1), 1);
        chk("rw_low", lcd_rw, 0);
        cap.push_back('{lcd_rs, lcd_data, init_done});
        first = 1'b0;
        last_clr = !lcd_rs && lcd_data == 8'h01;
        hi = 0;
      end
      if (lcd_e && prev_e) chk("bus_stable_e_high", {lcd_rs, lcd_data}, prev_bus);
      if (lcd_e) hi++;
      if (!lcd_e && prev_e) chk("e_width", hi, EP);
      lo = lcd_e ? 0 : lo + 1;
      prev_e = lcd_e;
      prev_bus = {lcd_rs, lcd_data};
    end
  end

  task automatic get_wr(output wr_t w);
    int t = 0;
    while (cap.size() == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (cap.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL get_wr: no E pulse within %0d clocks", t);
      w = '{1'b0, 8'h00, 1'b0};
    end else w = cap.pop_front();
  endtask

  // screen model: position 0..31, an address write before each line start or after a resume
  int   m_pos, m_frames;
  logic m_addr;
  task automatic check_next(input string tag);
    wr_t        w;
    logic [7:0] ed;
    get_wr(w);
    chk({tag, "_frames"}, fd_cnt, m_frames);
    ed = m_addr ? ((m_pos < 16 ? 8'h80 : 8'hC0) + 8'(m_pos % 16)) : scr[m_pos];
    chk({tag, "_rs"}, w.rs, !m_addr);
    chk({tag, "_data"}, w.data, ed);
    if (m_addr) m_addr = 1'b0;
    else begin
      if (m_pos == 31) m_frames++;
      m_pos = (m_pos + 1) % 32;
      m_addr = m_pos % 16 == 0;
    end
  endtask

  wr_t   tbl [38];
  string s1 = "SET  2000/00/00 ";
  string s2 = "TIME 00:00:00   ";

  task automatic run_table(input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      get_wr(w);
      chk($sformatf("tbl%0d_rs", i), w.rs, tbl[i].rs);
      chk($sformatf("tbl%0d_data", i), w.data, tbl[i].data);
      chk($sformatf("tbl%0d_init_done", i), w.idone, tbl[i].idone);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      scr[i] = s1[i];
      scr[16 + i] = s2[i];
    end
    tbl[0] = '{1'b0, 8'h38, 1'b0};
    tbl[1] = '{1'b0, 8'h0C, 1'b0};
    tbl[2] = '{1'b0, 8'h06, 1'b0};
    tbl[3] = '{1'b0, 8'h01, 1'b0};
    tbl[4] = '{1'b0, 8'h80, 1'b1};
    tbl[21] = '{1'b0, 8'hC0, 1'b1};
    for (int i = 0; i < 16; i++) begin
      tbl[5 + i] = '{1'b1, s1[i], 1'b1};
      tbl[22 + i] = '{1'b1, s2[i], 1'b1};
    end

    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_index", index, 0);
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b1;

    run_table(38);
    m_pos = 0; m_addr = 1'b1; m_frames = 0;
    m_frames = 1;

    lat2 = 1'b1;
    for (int k = 0; k < 34; k++) check_next("lat2");

    corrupt = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 32; i++) scr[i] = 8'($urandom_range(32, 126));
      lat2 = 1'($urandom_range(0, 1));
      for (int k = 0; k < 34; k++) check_next("rand");
    end

    for (int k = 0; k < 7; k++) check_next("pre_idle");
    en = 1'b0;
    chk("en_drop_mid_pulse", lcd_e, 1);
    repeat (60) @(negedge clk);
    chk("idle_no_e", cap.size(), 0);
    chk("idle_index", index, 6);
    en = 1'b1;
    m_addr = 1'b1;
    for (int k = 0; k < 3; k++) check_next("resume");

    for (int t = 0; t < 200 && !lcd_e; t++) @(negedge clk);
    chk("e_high_before_rst", lcd_e, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_e", lcd_e, 0);
    chk("async_rst_init_done", init_done, 0);
    chk("async_rst_index", index, 0);
    repeat (3) @(negedge clk);
    cap.delete();
    rst = 1'b1;
    run_table(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_char_driver.md
Name: lcd_char_driver

Overview:
- Downstream consumer of the watch "set" screen character generator.
- Sweeps `index` 0..31 and samples the registered ASCII byte returned on `char_in`.
- Drives a 16x2 HD44780-class character LCD over an 8-bit write-only bus: power-up wait, init command sequence, then continuous screen refresh (line 1 = index 0..15, line 2 = index 16..31).

Parameters:
- PWRUP_CYC, 750000, clocks to wait after reset before the first command (15 ms at 50 MHz).
- SETUP_CYC, 5, clocks RS/DATA are held stable before E rises.
- E_PULSE_CYC, 25, clocks E is held high.
- CMD_WAIT_CYC, 2000, clocks to wait after any write before the next one (40 us).
- CLEAR_WAIT_CYC, 82000, clocks to wait after the clear-display command (1.64 ms).
- CNT_W, 20, delay counter width; must hold the largest of the above.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- en, in, 1, refresh enable; when low, the current bus write completes, then the block idles.
- char_in, in, 8, ASCII byte from the character generator; valid 1 clock after `index` changes.
- index, out, 5, character position requested from the generator.
- lcd_e, out, 1, LCD enable strobe.
- lcd_rs, out, 1, register select (0 = command, 1 = data).
- lcd_rw, out, 1, read/write; tied 0 (write-only).
- lcd_data, out, 8, LCD data bus.
- init_done, out, 1, high once the init sequence is complete; stays high until reset.
- frame_done, out, 1, one-clock pulse after character 31 has been written.

Behaviour:
- Reset (async, rst=0): all outputs 0, index=0, state=PWR_WAIT, counter=0.
- Top FSM states: PWR_WAIT, INIT_CMD, SET_ADDR, FETCH, WR_CHAR, IDLE.
- PWR_WAIT:
  - Counts PWRUP_CYC clocks, then goes to INIT_CMD with step 0.
  - `en` is ignored here.
- INIT_CMD:
  - Issues 8'h38 (function set), 8'h0C (display on), 8'h06 (entry mode), 8'h01 (clear), in that order, all with RS=0.
  - The first three use CMD_WAIT_CYC; clear uses CLEAR_WAIT_CYC.
  - After clear completes: init_done <= 1, index <= 0, go to SET_ADDR.
- SET_ADDR:
  - Writes command 8'h80 when index==0, or 8'hC0 when index==16 (RS=0).
  - Then goes to FETCH.
- FETCH:
  - `index` is already stable; waits 2 clocks to cover the generator's 1-clock register latency.
  - Latches char_in into the write buffer, then goes to WR_CHAR.
- WR_CHAR:
  - Writes the latched byte with RS=1.
  - On completion, index increments with wrap 31 -> 0.
  - Pulses frame_done on the 31 -> 0 wrap.
  - If the new index is 0 or 16, go to SET_ADDR; otherwise go to FETCH.
- en=0 after init: at completion of the current write (never mid-pulse), go to IDLE with index unchanged. IDLE returns to SET_ADDR (address recomputed from index: 8'h80 + index[3:0] on line 1, 8'hC0 + index[3:0] on line 2) when en=1.
- Bus write cycle (lcd_bus_writer), driven by a req/done handshake:
  - Accepts req only when idle. req while busy is ignored.
  - On acceptance: lcd_rs and lcd_data are driven, lcd_e=0 for SETUP_CYC clocks.
  - Then lcd_e=1 for E_PULSE_CYC clocks.
  - Then lcd_e=0 with RS/DATA held for the wait count (CMD or CLEAR).
  - done pulses 1 clock at the end of the wait. Total = SETUP_CYC + E_PULSE_CYC + wait clocks from accept to done.
  - lcd_data and lcd_rs never change while lcd_e=1.
- Counter: single down-counter of CNT_W bits, loaded with (N-1), phase advances at 0. Parameters must be >=1.
- Reset mid-write: lcd_e drops to 0 immediately (async); the sequence restarts from PWR_WAIT.
- char_in changing during WR_CHAR has no effect (latched copy is used).

Decomposition:
- Package lcd_pkg:
  - Command constants: LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01, LCD_LINE1=8'h80, LCD_LINE2=8'hC0.
  - Top FSM state encoding.
- Sub-module lcd_bus_writer:
  - Ports: clk, rst, req, rs_in, data_in, long_wait, lcd_e, lcd_rs, lcd_data, done.
  - Parameterised by SETUP_CYC, E_PULSE_CYC, CMD_WAIT_CYC, CLEAR_WAIT_CYC.

Test Plan (PWRUP_CYC=10, SETUP_CYC=2, E_PULSE_CYC=3, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=8; character-generator model with 1-clock registered output):
1. Reset, then release -> no lcd_e edge for 10 clocks; then E pulses carry 38, 0C, 06, 01 with RS=0. Gap after 01 is 8 clocks. init_done rises after the clear's done.
2. Model returns "SET  2000/00/00 " / "TIME 00:00:00   " -> the sequence 80 (RS=0), then the line-1 bytes 53 45 54 20 20 32 30 30 30 2F 30 30 2F 30 30 20 (RS=1), then C0 (RS=0), then 54 49 4D 45 ... 20. frame_done pulses once after byte 31, then 80 again.
3. Timing check on every write -> RS/DATA stable 2 clocks before E rises and throughout E high. E high exactly 3 clocks. Next E rise no earlier than 4 clocks after E falls (8 after clear).
4. Model output deliberately delayed 1 clock vs index -> the driver still writes correct bytes (the 2-clock fetch wait covers it); a model forced to the wrong value only during WR_CHAR has no effect.
5. en dropped while index=5 is mid-pulse -> the pulse completes with the char at index 5. No further E edges while en=0. On en=1: command 8'h86, then char at index 6.
6. rst asserted while lcd_e=1 -> lcd_e=0 and init_done=0 immediately. After release, the full power-up wait plus init sequence repeats.
